// File: rtl/mem_if_write_framer.sv
// mem_if_write_framer: frames commands plus payload into a header+payload AXI4-Stream (clk, reset, cmd_*, s_axis_*, tx_axis_*, idle_out, state_vec_out)
module mem_if_write_framer (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  cmd_buf_idx,
  input  logic [11:0] cmd_beat_addr,
  input  logic [11:0] cmd_beat_len,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [63:0] tx_axis_tdata,
  output logic        tx_axis_tlast,
  output logic        tx_axis_tvalid,
  input  logic        tx_axis_tready,
  output logic        idle_out,
  output logic [31:0] state_vec_out
);
  localparam int AXI4S_DATA_WIDTH    = 64;
  localparam int MEM_BUF_IDX_WIDTH   = 4;
  localparam int MEM_BEAT_ADDR_WIDTH = 12;
  localparam int MEM_ADDR_POS        = 0;
  localparam int MEM_BUF_IDX_POS     = 16;
  localparam int MEM_LENGTH_POS      = 32;
  typedef enum logic [1:0] {STATE_IDLE = 2'd0, STATE_DATA = 2'd1} state_t;
  state_t state, state_n;
  logic [MEM_BEAT_ADDR_WIDTH-1:0] remaining;
  logic [15:0] pkt_count;
  logic zero_len_err;
  logic slot_free, cmd_fire, dat_fire, len_zero, last_beat;
  logic [AXI4S_DATA_WIDTH-1:0] hdr;
  logic [7:0] state_code;
  assign slot_free = ~tx_axis_tvalid | tx_axis_tready;
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign dat_fire  = s_axis_tvalid & s_axis_tready;
  assign len_zero  = cmd_beat_len == '0;
  assign last_beat = remaining == MEM_BEAT_ADDR_WIDTH'(1);
  always_comb begin
    hdr = '0;
    hdr[MEM_ADDR_POS +: MEM_BEAT_ADDR_WIDTH]  = cmd_beat_addr;
    hdr[MEM_BUF_IDX_POS +: MEM_BUF_IDX_WIDTH] = cmd_buf_idx;
    hdr[MEM_LENGTH_POS +: MEM_BEAT_ADDR_WIDTH] = cmd_beat_len;
  end
  always_comb begin
    cmd_ready     = ~reset & (state == STATE_IDLE) & slot_free;
    s_axis_tready = ~reset & (state == STATE_DATA) & slot_free;
    state_n = state == STATE_IDLE ? ((cmd_fire & ~len_zero) ? STATE_DATA : STATE_IDLE) :
              state == STATE_DATA ? ((dat_fire & last_beat) ? STATE_IDLE : STATE_DATA) :
              STATE_IDLE;
    state_code = state == STATE_IDLE ? 8'h00 : state == STATE_DATA ? 8'h01 : 8'hFF;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= STATE_IDLE;
      remaining      <= '0;
      pkt_count      <= '0;
      zero_len_err   <= 1'b0;
      tx_axis_tdata  <= '0;
      tx_axis_tlast  <= 1'b0;
      tx_axis_tvalid <= 1'b0;
      idle_out       <= 1'b1;
      state_vec_out  <= '0;
    end else begin
      state <= state_n;
      if (cmd_fire && !len_zero) begin
        tx_axis_tdata  <= hdr;
        tx_axis_tlast  <= 1'b0;
        tx_axis_tvalid <= 1'b1;
        remaining      <= cmd_beat_len;
      end else if (dat_fire) begin
        tx_axis_tdata  <= s_axis_tdata;
        tx_axis_tlast  <= last_beat;
        tx_axis_tvalid <= 1'b1;
        remaining      <= remaining - 1'b1;
        if (last_beat) pkt_count <= pkt_count + 16'd1;
      end else if (tx_axis_tready) begin
        tx_axis_tvalid <= 1'b0;
      end
      if (cmd_fire && len_zero) zero_len_err <= 1'b1;
      idle_out      <= (state == STATE_IDLE) & ~tx_axis_tvalid;
      state_vec_out <= {pkt_count, 3'b000, zero_len_err, cmd_valid, cmd_ready, s_axis_tvalid, tx_axis_tready, state_code};
    end
  end
endmodule

// File: tb/tb_mem_if_write_framer.sv
// tb_mem_if_write_framer: randomized scoreboard bench for mem_if_write_framer
module tb_mem_if_write_framer;
  localparam int BUF_POS = 16;
  localparam int LEN_POS = 32;
  logic clk = 0, reset = 1;
  logic [3:0] cmd_buf_idx = 0;
  logic [11:0] cmd_beat_addr = 0, cmd_beat_len = 0;
  logic cmd_valid = 0, cmd_ready;
  logic [63:0] s_axis_tdata = 0;
  logic s_axis_tvalid = 0, s_axis_tready;
  logic [63:0] tx_axis_tdata;
  logic tx_axis_tlast, tx_axis_tvalid, tx_axis_tready = 0;
  logic idle_out;
  logic [31:0] state_vec_out;
  mem_if_write_framer dut (
    .clk(clk), .reset(reset),
    .cmd_buf_idx(cmd_buf_idx), .cmd_beat_addr(cmd_beat_addr), .cmd_beat_len(cmd_beat_len),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .tx_axis_tdata(tx_axis_tdata), .tx_axis_tlast(tx_axis_tlast), .tx_axis_tvalid(tx_axis_tvalid),
    .tx_axis_tready(tx_axis_tready), .idle_out(idle_out), .state_vec_out(state_vec_out)
  );
  always #5 clk = ~clk;
  int vectors = 0, miscompares = 0;
  logic [64:0] exp_q[$];
  logic [63:0] pay_q[$];
  int n_pkts = 0;
  bit exp_err = 0;
  bit full_rate = 0;
  bit log_en = 0;
  bit log_v[$], log_l[$];
  int beats_seen = 0;
  logic prev_v = 0, prev_r = 0, prev_l = 0;
  logic [63:0] prev_d = 0;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask
  initial forever begin
    @(posedge clk); #1;
    tx_axis_tready = full_rate ? 1'b1 : ($urandom_range(0, 3) != 0);
    if (pay_q.size() > 0 && (full_rate || $urandom_range(0, 2) != 0)) begin
      s_axis_tvalid = 1;
      s_axis_tdata  = pay_q[0];
    end else begin
      s_axis_tvalid = 0;
      s_axis_tdata  = {$urandom, $urandom};
    end
  end
  always @(negedge clk) if (!reset && s_axis_tvalid && s_axis_tready && pay_q.size() > 0) void'(pay_q.pop_front());
  always @(negedge clk) begin
    if (reset) prev_v <= 0;
    else begin
      if (log_en) begin
        log_v.push_back(tx_axis_tvalid);
        log_l.push_back(tx_axis_tlast);
      end
      if (prev_v && !prev_r) begin
        vectors++;
        if (!tx_axis_tvalid || tx_axis_tdata !== prev_d || tx_axis_tlast !== prev_l) begin
          miscompares++;
          $display("FAIL hold: got v=%b d=%h l=%b want v=1 d=%h l=%b", tx_axis_tvalid, tx_axis_tdata, tx_axis_tlast, prev_d, prev_l);
        end
      end
      if (tx_axis_tvalid && tx_axis_tready) begin
        vectors++;
        beats_seen++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL beat: got unexpected l=%b d=%h want no beat", tx_axis_tlast, tx_axis_tdata);
        end else begin
          logic [64:0] e;
          e = exp_q.pop_front();
          if ({tx_axis_tlast, tx_axis_tdata} !== e) begin
            miscompares++;
            $display("FAIL beat: got l=%b d=%h want l=%b d=%h", tx_axis_tlast, tx_axis_tdata, e[64], e[63:0]);
          end
        end
      end
      prev_v <= tx_axis_tvalid;
      prev_r <= tx_axis_tready;
      prev_d <= tx_axis_tdata;
      prev_l <= tx_axis_tlast;
    end
  end
  task automatic issue(input logic [3:0] b, input logic [11:0] a, input logic [11:0] l, input logic [63:0] d0, input bit fixed);
    int n = 0;
    bit done = 0;
    cmd_buf_idx = b; cmd_beat_addr = a; cmd_beat_len = l; cmd_valid = 1;
    while (!done && n < 2000) begin
      @(negedge clk);
      if (cmd_ready) begin
        done = 1;
        if (l == 0) exp_err = 1;
        else begin
          exp_q.push_back({1'b0, (64'(l) << LEN_POS) | (64'(b) << BUF_POS) | 64'(a)});
          for (int i = 0; i < int'(l); i++) begin
            logic [63:0] d;
            d = fixed ? d0 + 64'(i) : {$urandom, $urandom};
            pay_q.push_back(d);
            exp_q.push_back({i == int'(l) - 1, d});
          end
          n_pkts++;
        end
      end
      @(posedge clk); #1;
      n++;
    end
    cmd_valid = 0;
    if (!done) chk("cmd_accept_timeout", 0, 1);
  endtask
  task automatic drain(input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && pay_q.size() == 0 && idle_out) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 5000) chk("drain_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_pkt_count"}, 64'(state_vec_out[31:16]), 64'(n_pkts[15:0]));
    chk({name, "_zero_len_err"}, 64'(state_vec_out[12]), 64'(exp_err));
    chk({name, "_state"}, 64'(state_vec_out[7:0]), 0);
    chk({name, "_idle"}, 64'(idle_out), 1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 64'(tx_axis_tvalid), 0);
    chk("rst_tlast", 64'(tx_axis_tlast), 0);
    chk("rst_tdata", tx_axis_tdata, 0);
    chk("rst_cmd_ready", 64'(cmd_ready), 0);
    chk("rst_s_tready", 64'(s_axis_tready), 0);
    chk("rst_idle", 64'(idle_out), 1);
    chk("rst_state_vec", 64'(state_vec_out), 0);
    @(posedge clk); #1;
    reset = 0;
    issue(4'd1, 12'h010, 12'd1, 64'hA5, 1);
    drain("single");
    full_rate = 1;
    @(posedge clk); #1;
    log_en = 1;
    issue(4'd2, 12'h020, 12'd2, 64'h100, 1);
    issue(4'd3, 12'h030, 12'd3, 64'h200, 1);
    drain("b2b");
    log_en = 0;
    begin
      int s = -1;
      logic [6:0] gv = 0, gl = 0;
      for (int i = 0; i < log_v.size(); i++) if (s < 0 && log_v[i]) s = i;
      if (s < 0 || s + 8 > log_v.size()) chk("b2b_window", 0, 1);
      else begin
        for (int i = 0; i < 7; i++) begin
          gv[i] = log_v[s + i];
          gl[i] = log_l[s + i];
        end
        chk("b2b_valid_run", 64'(gv), 64'h7F);
        chk("b2b_tlast_pos", 64'(gl), 64'b1000100);
        chk("b2b_gap_after", 64'(log_v[s + 7]), 0);
      end
    end
    full_rate = 0;
    issue(4'd4, 12'h040, 12'd0, 0, 0);
    drain("zero_len");
    issue(4'd5, 12'h050, 12'd1, 64'h55, 1);
    drain("after_zero");
    for (int k = 0; k < 30; k++) begin
      logic [11:0] l;
      l = ($urandom_range(0, 9) == 0) ? 12'd0 : 12'($urandom_range(1, 7));
      if (k % 10 == 9) full_rate = ~full_rate;
      issue(4'($urandom), 12'($urandom), l, 0, 0);
    end
    full_rate = 0;
    drain("random");
    full_rate = 1;
    beats_seen = 0;
    issue(4'd6, 12'h060, 12'd5, 0, 0);
    begin
      int n = 0;
      while (beats_seen < 3 && n < 1000) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 1000) chk("midrst_wait_timeout", 0, 1);
    end
    reset = 1;
    exp_q.delete();
    pay_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_tvalid", 64'(tx_axis_tvalid), 0);
    chk("midrst_s_tready", 64'(s_axis_tready), 0);
    chk("midrst_state_vec", 64'(state_vec_out), 0);
    @(posedge clk); #1;
    reset = 0;
    n_pkts = 0;
    exp_err = 0;
    full_rate = 0;
    issue(4'd7, 12'h070, 12'd1, 64'h77, 1);
    drain("post_rst");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_if_write_framer.md
# mem_if_write_framer

Packetizes a raw feature-data stream into the header-plus-payload AXI4-Stream format consumed by the memory-interface writer. For each write command (buffer index, beat address, beat length) it emits one header beat, then forwards exactly `length` payload beats, with `tlast` on the final payload beat. It sits directly upstream of the DDR writer's `rx_axis` port and downstream of the compute-engine output stage and its command generator.

## Interface
- Parameters: none; widths come from `axi4_params.v`, `axi3_params.v` and `mem_params.v` (`AXI4S_DATA_WIDTH`, `AXI4L_DATA_WIDTH`, `MEM_BUF_IDX_WIDTH`, `MEM_BEAT_ADDR_WIDTH`, `MEM_ADDR_POS`, `MEM_ADDR_WIDTH`, `MEM_BUF_IDX_POS`, `MEM_LENGTH_POS`).
- Clocking and reset (already decided): one clock; reset is synchronous and active-high.
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `cmd_buf_idx`  in  MEM_BUF_IDX_WIDTH  target buffer index.
- `cmd_beat_addr`  in  MEM_BEAT_ADDR_WIDTH  start beat address within the buffer.
- `cmd_beat_len`  in  MEM_BEAT_ADDR_WIDTH  payload beat count.
- `cmd_valid`  in  1  command valid.
- `cmd_ready`  out  1  command accept.
- `s_axis_tdata`  in  AXI4S_DATA_WIDTH  payload data.
- `s_axis_tvalid`  in  1  payload valid.
- `s_axis_tready`  out  1  payload accept.
- `tx_axis_tdata`  out  AXI4S_DATA_WIDTH  framed stream to the writer's `rx_axis_tdata`.
- `tx_axis_tlast`  out  1  high on the last payload beat only.
- `tx_axis_tvalid`  out  1  framed beat valid (registered).
- `tx_axis_tready`  in  1  writer accept.
- `idle_out`  out  1  no packet in progress and output register empty.
- `state_vec_out`  out  AXI4L_DATA_WIDTH  debug status.

## Operation
- One output register holds `tdata`/`tlast`/`tvalid`. Define `slot_free = ~tx_axis_tvalid | tx_axis_tready`. The register loads only when `slot_free`.
- FSM states: `STATE_IDLE` = 0, `STATE_DATA` = 1.
- `STATE_IDLE`:
  - `cmd_ready = slot_free`; `s_axis_tready = 0`.
  - When `cmd_valid & cmd_ready` and `cmd_beat_len != 0`:
    - Load the header beat: `cmd_beat_addr` at `MEM_ADDR_POS`, `cmd_buf_idx` at `MEM_BUF_IDX_POS`, `cmd_beat_len` at `MEM_LENGTH_POS`. Every other bit is 0 and `tlast` = 0.
    - Set `remaining <= cmd_beat_len` and go to `STATE_DATA`.
  - When `cmd_valid & cmd_ready` and `cmd_beat_len == 0`:
    - The command is consumed and nothing is emitted.
    - Set the sticky `zero_len_err`; the state stays `STATE_IDLE`.
- `STATE_DATA`:
  - `cmd_ready = 0`; `s_axis_tready = slot_free`.
  - On each `s_axis_tvalid & s_axis_tready`:
    - Load `s_axis_tdata` into the output register and decrement `remaining`.
    - `tlast = (remaining == 1)`. When that beat loads, return to `STATE_IDLE` and increment `pkt_count`.
- A beat in the output register that is not accepted holds `tdata`/`tlast`/`tvalid` stable until `tx_axis_tready`.
- `remaining` is `MEM_BEAT_ADDR_WIDTH` wide. The maximum length is `2^MEM_BEAT_ADDR_WIDTH - 1`, and there is no wrap handling inside a packet.
- `pkt_count` is 16 bits and wraps from 0xFFFF to 0.
- `idle_out = (state == STATE_IDLE) & ~tx_axis_tvalid`, registered one cycle.
- `state_vec_out` (registered):
  - [7:0] = state, with 0xFF for an illegal state.
  - [15:8] = {3'b0, `zero_len_err`, `cmd_valid`, `cmd_ready`, `s_axis_tvalid`, `tx_axis_tready`}.
  - [31:16] = `pkt_count`.
- Reset values: `tx_axis_tvalid` = 0, `tx_axis_tlast` = 0, `tx_axis_tdata` = 0, `cmd_ready` = 0 in the reset cycle, `s_axis_tready` = 0, `idle_out` = 1, `state_vec_out` = 0, `zero_len_err` = 0, `pkt_count` = 0, state = `STATE_IDLE`.
- Reset mid-packet: the partial packet is abandoned, the output register is cleared, and no `tlast` is emitted. Recovery of the downstream writer is the system's responsibility.

## Timing
- Command accepted in cycle N: the header has `tx_axis_tvalid` = 1 from cycle N+1.
- With no backpressure, payload beats follow at one per cycle. A packet of L beats occupies L+1 output cycles.
- Back-to-back commands: a new command can be accepted in the cycle after the last payload beat loads. The header then appears immediately after that beat, with no bubble when `tx_axis_tready` = 1.
- `cmd_ready` and `s_axis_tready` are combinational from the state and `tx_axis_tready`. They never depend on `cmd_valid` or `s_axis_tvalid`.
- Payload offered in `STATE_IDLE` is not accepted; `s_axis_tready` = 0 there.
- `zero_len_err` sets in the cycle after acceptance and is cleared only by reset.

## Test plan
- Command buf = 1, addr = 0x10, len = 1, payload 0xA5 -> two beats: the header with the fields at their positions and `tlast` = 0, then 0xA5 with `tlast` = 1. `pkt_count` = 1.
- Command len = 4 with `tx_axis_tready` toggling 1,0,0,1,... -> all 5 beats are delivered in order, data is held stable while stalled, and `tlast` is only on the 4th payload beat.
- Two commands back-to-back (len = 2, len = 3) with `tready` = 1 -> 7 consecutive valid cycles with no gap, and `tlast` on output beats 3 and 7.
- Command len = 0 -> `cmd_ready` pulses and no `tx_axis_tvalid` appears. `state_vec_out[12]` = 1, `pkt_count` is unchanged, and a following len = 1 command frames normally.
- Upstream bubbles (`s_axis_tvalid` 1,0,1,0) on a len = 2 command -> the output contains only valid beats, `remaining` decrements only on handshakes, and `idle_out` returns to 1 two cycles after the last beat is accepted.
- Reset asserted after 2 of 5 payload beats -> the next cycle shows `tx_axis_tvalid` = 0, `s_axis_tready` = 0 and `state_vec_out` = 0. A new len = 1 command then produces a correct header and payload.
